// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and decode: opcode values,
// the canonical NOP word and the fetch state encoding.
package fetch_unit_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    // addi x0, x0, 0 -- what a bubble looks like in IF/ID
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_flopenrc.sv
// Register with synchronous reset, enable and synchronous clear.
// Reset and clear both load CLR_VAL; priority is rst > clr > en.
module fetch_unit_flopenrc #(
    parameter int           W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register update: reset/clear load the clear value, enable loads d
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALTED state machine. A halt opcode stops fetch speculatively; a
// redirect from EX cancels it.
//
// Handshake note: there is no valid/ready pair here. stall is a hold
// request (PC, IF/ID and state freeze), pc_sel is a redirect that wins
// over stall, and ifid_valid qualifies ifid_instr for the decode stage.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [PC_W-1:0]  target_pc,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic             ifid_valid,
    output logic             halted,
    output logic             dbg_state
);

    localparam int IFID_W = PC_W + INS_W + 1;
    localparam logic [IFID_W-1:0] IFID_BUBBLE =
        {{PC_W{1'b0}}, INS_W'(NOP_INSTR), 1'b0};

    fetch_state_t      state_q;
    fetch_state_t      state_n;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_clr;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;
    logic              is_halt;

    assign is_halt = (imem_rdata[6:0] == OP_HALT);
    assign ifid_d  = {pc_q, imem_rdata, 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and register controls: pc_sel > stall > normal fetch
    always_comb begin
        state_n  = state_q;
        pc_en    = 1'b0;
        pc_d     = pc_q;
        ifid_en  = 1'b0;
        ifid_clr = 1'b0;
        if (pc_sel) begin
            // Redirect: bubble IF/ID, cancel any speculative halt
            pc_en    = 1'b1;
            pc_d     = target_pc;
            ifid_clr = 1'b1;
            state_n  = RUN;
        end else if (stall) begin
            // Everything holds, including a pending halt decision
            state_n = state_q;
        end else if (state_q == RUN) begin
            ifid_en = 1'b1;
            if (is_halt) begin
                state_n = HALTED;
            end else begin
                pc_en = 1'b1;
                pc_d  = pc_q + PC_W'(4);
            end
        end else begin
            // HALTED: PC frozen, feed bubbles downstream
            ifid_clr = 1'b1;
        end
    end

    fetch_unit_flopenrc #(
        .W       (PC_W),
        .CLR_VAL ({PC_W{1'b0}})
    ) u_pc_reg (
        .clk (clk),
        .rst (reset),
        .en  (pc_en),
        .clr (1'b0),
        .d   (pc_d),
        .q   (pc_q)
    );

    fetch_unit_flopenrc #(
        .W       (IFID_W),
        .CLR_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk (clk),
        .rst (reset),
        .en  (ifid_en),
        .clr (ifid_clr),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_q[IFID_W-1 -: PC_W];
    assign ifid_instr = ifid_q[INS_W:1];
    assign ifid_valid = ifid_q[0];
    assign halted     = (state_q == HALTED);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model predicts each
// cycle's outputs into a scoreboard queue, which is popped and compared
// after the edge. Directed scenarios add constant checks.
module tb_fetch_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int EW    = PC_W + PC_W + INS_W + 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             pc_sel;
    logic [PC_W-1:0]  target_pc;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic [PC_W-1:0]  ifid_pc;
    logic [INS_W-1:0] ifid_instr;
    logic             ifid_valid;
    logic             halted;
    logic             dbg_state;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model state
    logic [PC_W-1:0]  m_pc;
    logic [PC_W-1:0]  m_ifid_pc;
    logic [INS_W-1:0] m_ifid_instr;
    logic             m_ifid_valid;
    logic             m_halted;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    // Instruction memory: halt words at 0x020 and 0x100, otherwise
    // an addi whose immediate encodes the address (distinct per word).
    function automatic logic [INS_W-1:0] imem_word(input logic [PC_W-1:0] a);
        if (a == 9'h020 || a == 9'h100) return 32'h00000000;
        return {3'b000, a, 5'd1, 3'b000, 5'd1, 7'b0010011};
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    fetch_unit #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .target_pc  (target_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive inputs, predict, let one
    // rising edge pass, then compare on the next falling edge.
    task automatic step(input logic r, input logic s, input logic p,
                        input logic [PC_W-1:0] t);
        logic [INS_W-1:0] w;
        logic [EW-1:0]    e;
        reset     = r;
        stall     = s;
        pc_sel    = p;
        target_pc = t;
        w = imem_word(m_pc);
        if (r) begin
            m_pc = '0; m_halted = 1'b0;
            m_ifid_pc = '0; m_ifid_instr = 32'h00000013; m_ifid_valid = 1'b0;
        end else if (p) begin
            m_pc = t; m_halted = 1'b0;
            m_ifid_pc = '0; m_ifid_instr = 32'h00000013; m_ifid_valid = 1'b0;
        end else if (s) begin
            // hold
        end else if (!m_halted) begin
            m_ifid_pc = m_pc; m_ifid_instr = w; m_ifid_valid = 1'b1;
            if (w[6:0] == 7'b0000000) m_halted = 1'b1;
            else m_pc = m_pc + 9'd4;
        end else begin
            m_ifid_pc = '0; m_ifid_instr = 32'h00000013; m_ifid_valid = 1'b0;
        end
        exp_q.push_back({m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid, m_halted, m_halted});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("imem_addr",  32'(imem_addr),  32'(e[EW-1 -: PC_W]));
        check("ifid_pc",    32'(ifid_pc),    32'(e[EW-PC_W-1 -: PC_W]));
        check("ifid_instr", ifid_instr,      e[INS_W+2:3]);
        check("ifid_valid", 32'(ifid_valid), 32'(e[2]));
        check("halted",     32'(halted),     32'(e[1]));
        check("dbg_state",  32'(dbg_state),  32'(e[0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; target_pc = '0;
        @(negedge clk);

        // Reset, overriding a redirect and a stall in the same cycle
        step(1'b1, 1'b1, 1'b1, 9'h040);
        check("rst_pc",    32'(imem_addr),  32'h0);
        check("rst_instr", ifid_instr,      32'h00000013);
        check("rst_valid", 32'(ifid_valid), 32'h0);
        check("rst_halt",  32'(halted),     32'h0);

        // Free-running fetch from 0
        run(3);
        check("free_addr12", 32'(imem_addr), 32'h00C);
        check("free_ifid8",  32'(ifid_pc),   32'h008);
        check("free_instr",  ifid_instr,     32'h00808093);

        // Reset again and stall at PC=8
        step(1'b1, 1'b0, 1'b0, '0);
        run(2);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("stall_addr", 32'(imem_addr), 32'h008);
        check("stall_ifid", 32'(ifid_pc),   32'h004);
        run(1);
        check("resume_addr", 32'(imem_addr), 32'h00C);

        // Redirect wins over stall at PC=0x10
        run(1);
        check("pre_redir", 32'(imem_addr), 32'h010);
        step(1'b0, 1'b1, 1'b1, 9'h040);
        check("redir_addr",  32'(imem_addr),  32'h040);
        check("redir_valid", 32'(ifid_valid), 32'h0);
        check("redir_instr", ifid_instr,      32'h00000013);

        // Unaligned target used as given
        step(1'b0, 1'b0, 1'b1, 9'h042);
        check("unaligned", 32'(imem_addr), 32'h042);

        // Halt at 0x20
        step(1'b0, 1'b0, 1'b1, 9'h018);
        run(2);
        run(1);
        check("halt_instr", ifid_instr,      32'h00000000);
        check("halt_valid", 32'(ifid_valid), 32'h1);
        check("halt_flag",  32'(halted),     32'h1);
        check("halt_addr",  32'(imem_addr),  32'h020);
        run(2);
        check("halt_bubble", 32'(ifid_valid), 32'h0);
        check("halt_hold",   32'(imem_addr),  32'h020);
        step(1'b0, 1'b1, 1'b0, '0);

        // Redirect out of HALTED
        step(1'b0, 1'b0, 1'b1, 9'h008);
        check("unhalt", 32'(halted), 32'h0);
        run(2);
        check("unhalt_fetch", 32'(ifid_pc), 32'h00C);

        // Halt word reached under stall: no state change until release
        step(1'b0, 1'b0, 1'b1, 9'h020);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("stall_halt", 32'(halted), 32'h0);
        run(1);
        check("stall_halt_rel", 32'(halted), 32'h1);

        // Wrap at 0x1FC, then reset while halted
        step(1'b0, 1'b0, 1'b1, 9'h1FC);
        run(1);
        check("wrap_addr", 32'(imem_addr), 32'h000);
        check("wrap_ifid", 32'(ifid_pc),   32'h1FC);
        step(1'b0, 1'b0, 1'b1, 9'h100);
        run(2);
        check("halt2", 32'(halted), 32'h1);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rst_halt_pc",  32'(imem_addr), 32'h000);
        check("rst_halt_flg", 32'(halted),    32'h0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 9'($urandom_range(0, 127) * 4 + ($urandom_range(0, 9) == 0 ? 2 : 0)));
        end

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 9, program-counter and instruction-memory byte-address width.
REQ-002 Parameter: INS_W, 32, instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard stall; hold PC and IF/ID contents.
REQ-006 pc_sel  input  1  redirect request from EX (taken branch, jal, jalr).
REQ-007 target_pc  input  PC_W  redirect destination, valid when pc_sel=1.
REQ-008 imem_addr  output  PC_W  instruction-memory address; equals current PC.
REQ-009 imem_rdata  input  INS_W  instruction word, combinational read of imem_addr.
REQ-010 ifid_pc  output  PC_W  PC of the instruction held in IF/ID.
REQ-011 ifid_instr  output  INS_W  instruction held in IF/ID; opcode field [6:0] drives decode control.
REQ-012 ifid_valid  output  1  1 = ifid_instr is a real fetched instruction, 0 = bubble.
REQ-013 halted  output  1  1 while fetch is stopped on a halt opcode.

Function
REQ-014 State machine shall have two states: RUN (fetching) and HALTED (PC frozen).
REQ-015 Per-cycle priority shall be: reset > pc_sel > stall > normal fetch.
REQ-016 Normal fetch in RUN: PC <= PC+4 modulo 2^PC_W; IF/ID <= {PC, imem_rdata, valid=1}.
REQ-017 Fetch latency shall be one cycle: the word at address A appears on ifid_instr the cycle after imem_addr=A.
REQ-018 PC increment shall wrap: PC = 2^PC_W-4 is followed by PC = 0, no error flag.
REQ-019 pc_sel=1: PC <= target_pc; IF/ID <= bubble (instr 32'h00000013, valid=0, ifid_pc=0); state <= RUN; stall ignored that cycle.
REQ-020 stall=1 with pc_sel=0: PC, IF/ID and state shall hold unchanged.
REQ-021 In RUN, no stall/redirect, imem_rdata[6:0]=7'b0000000 (halt): the halt word is loaded into IF/ID with valid=1, PC holds, state <= HALTED.
REQ-022 A halt opcode arriving during stall shall not change state until the stall releases.
REQ-023 In HALTED without pc_sel: PC holds; IF/ID <= bubble every cycle unless stall=1 (then hold).
REQ-024 pc_sel=1 in HALTED shall cancel the speculative halt: PC <= target_pc, state <= RUN, halted falls the next cycle.
REQ-025 halted shall be a registered output equal to (state==HALTED).
REQ-026 target_pc bits [1:0] shall be used as given; no alignment correction.

Reset
REQ-027 On reset=1 at a rising edge: PC=0, state=RUN, halted=0, ifid_pc=0, ifid_instr=32'h00000013, ifid_valid=0.
REQ-028 Reset shall override pc_sel, stall and a halt opcode in the same cycle; reset mid-HALTED returns to RUN at PC=0.
REQ-029 The first fetch after reset deasserts shall be from address 0, loading IF/ID on the following edge.

Structure
REQ-030 Shared package shall hold: opcode constants (R-type 0110011, load 0000011, store 0100011, branch 1100011, op-imm 0010011, jal 1101111, jalr 1100111, halt 0000000), NOP constant 32'h00000013, fetch state enum {RUN, HALTED}.
REQ-031 Decode control logic and fetch_unit shall take opcode values only from that package.
REQ-032 One sub-module is natural: flopenrc (parameterised width, synchronous reset, enable, synchronous clear), instantiated for PC and IF/ID.

Verification
REQ-033 Reset then 4 free cycles, imem returns addi words -> imem_addr 0,4,8,12; ifid_pc 0,4,8 with valid=1 from cycle 2.
REQ-034 stall held 2 cycles at PC=8 -> imem_addr stays 8, ifid_pc stays 4 for both cycles, resumes 12 after release.
REQ-035 pc_sel=1, target_pc=0x40 with stall=1 at PC=0x10 -> next imem_addr=0x40, ifid_valid=0, ifid_instr=0x00000013.
REQ-036 Halt word at 0x20 -> ifid_instr=0x00000000 valid=1, then halted=1, imem_addr held at 0x20, following IF/ID bubbles.
REQ-037 While halted, pc_sel=1 target_pc=0x08 -> halted=0 next cycle, fetch resumes 0x08, 0x0C.
REQ-038 PC_W=9, PC=0x1FC free-running -> next imem_addr=0x000; reset asserted while halted -> PC=0, halted=0.
